// File: rtl/cgra_pkg.sv
// Shared CGRA definitions.
// Holds the direction index map used by every PE-level block and the state
// encoding of the transmit-side fork.
package cgra_pkg;

    // Direction / branch indices into per-direction vectors.
    localparam int DIR_N  = 32'sd0;
    localparam int DIR_E  = 32'sd1;
    localparam int DIR_S  = 32'sd2;
    localparam int DIR_W  = 32'sd3;
    localparam int DIR_FU = 32'sd4;
    localparam int N_DIRS = 32'sd5;

    // Fork occupancy: no token held, or one token being delivered.
    typedef enum logic [0:0] {
        FORK_EMPTY = 1'b0,
        FORK_HOLD  = 1'b1
    } fork_state_e;

endpackage : cgra_pkg

// File: rtl/fork_branch.sv
// One output branch of the eager fork.
// Tracks whether the current token has already been delivered on this branch
// and reports whether the branch is "satisfied" so the parent can retire the
// token once every branch is.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   hold       parent currently holds a token
//   mask_bit   this branch is a destination of the held token
//   load       a new token is captured at the next edge
//   out_ready  consumer ready for this branch
//   out_valid  token offered on this branch
//   satisfied  branch owes nothing for the held token (after this cycle)
module fork_branch (
    input  logic clock,
    input  logic reset,
    input  logic hold,
    input  logic mask_bit,
    input  logic load,
    input  logic out_ready,
    output logic out_valid,
    output logic satisfied
);

    logic done_r;
    logic fire_s;

    // Offer depends only on registered state, never on out_ready.
    assign out_valid = hold & mask_bit & ~done_r;
    assign fire_s    = out_valid & out_ready;
    assign satisfied = ~mask_bit | done_r | fire_s;

    // Delivered flag: cleared by a new token (which wins over a same-cycle
    // fire of the old one), set once the branch has handed the token over.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_r <= 1'b0;
        end else if (load) begin
            done_r <= 1'b0;
        end else if (fire_s) begin
            done_r <= 1'b1;
        end else begin
            done_r <= done_r;
        end
    end

endmodule : fork_branch

// File: rtl/fork_sender.sv
// Transmit-side elastic eager fork of a CGRA PE.
// Takes one valid/ready token stream and delivers each token to every branch
// selected by the mask sampled at load time (N, E, S, W, FU). Branches
// handshake independently; the token retires once every selected branch has
// taken it, and a new token may be loaded on the same edge.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   io_cfg_mask    branch enable, sampled only when a token is loaded
//   io_in_valid/io_in_ready/io_in_bits    producer handshake and data
//   io_out_valid/io_out_ready             per-branch handshake
//   io_out_bits    held token data, shared by all branches
//   io_busy        a token is held
//   io_count       fully delivered tokens, saturating
module fork_sender
    import cgra_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_OUT = N_DIRS,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_OUT-1:0] io_cfg_mask,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_bits,
    output logic [N_OUT-1:0] io_out_valid,
    input  logic [N_OUT-1:0] io_out_ready,
    output logic [WIDTH-1:0] io_out_bits,
    output logic             io_busy,
    output logic [CNT_W-1:0] io_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fork_state_e      state_r;
    fork_state_e      state_s;
    logic [WIDTH-1:0] data_r;
    logic [N_OUT-1:0] mask_r;
    logic [CNT_W-1:0] count_r;
    logic [N_OUT-1:0] satisfied_s;
    logic             hold_s;
    logic             retire_s;
    logic             accept_s;
    logic             load_s;

    assign hold_s   = (state_r == FORK_HOLD);
    assign retire_s = hold_s & (&satisfied_s);
    // Ready passes straight through from the branch readies via retire, so a
    // fully-ready fan-out streams one token per cycle without bubbles.
    assign io_in_ready = ~hold_s | retire_s;
    assign accept_s    = io_in_valid & io_in_ready;
    // A zero-mask token is accepted but dropped: nothing to deliver.
    assign load_s      = accept_s & (|io_cfg_mask);

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_branch
            fork_branch u_branch (
                .clock     (clock),
                .reset     (reset),
                .hold      (hold_s),
                .mask_bit  (mask_r[gi]),
                .load      (load_s),
                .out_ready (io_out_ready[gi]),
                .out_valid (io_out_valid[gi]),
                .satisfied (satisfied_s[gi])
            );
        end
    endgenerate

    assign io_out_bits = data_r;
    assign io_busy     = hold_s;
    assign io_count    = count_r;

    // Next-state logic: a retiring token hands over to a same-edge load.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FORK_EMPTY: begin
                if (load_s) begin
                    state_s = FORK_HOLD;
                end else begin
                    state_s = FORK_EMPTY;
                end
            end
            FORK_HOLD: begin
                if (load_s) begin
                    state_s = FORK_HOLD;
                end else if (retire_s) begin
                    state_s = FORK_EMPTY;
                end else begin
                    state_s = FORK_HOLD;
                end
            end
            default: begin
                state_s = FORK_EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= FORK_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Token capture: data and destination mask are frozen at load time.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_r <= {WIDTH{1'b0}};
            mask_r <= {N_OUT{1'b0}};
        end else if (load_s) begin
            data_r <= io_in_bits;
            mask_r <= io_cfg_mask;
        end else begin
            data_r <= data_r;
            mask_r <= mask_r;
        end
    end

    // Delivered-token counter, sticks at its maximum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (retire_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule : fork_sender

// File: doc/fork_sender.md
# fork_sender

Transmit-side elastic eager fork for a CGRA processing element. It accepts one valid/ready token stream and delivers each token to every direction selected in a per-token mask. The outputs are north, east, south, west and the local FU. Each output completes its handshake independently. It is the sending counterpart of the per-direction ready/valid combining logic on the receive side, and it sits between a PE's result register and the four switch-box links plus the FU input.

## Interface
- WIDTH, 32, data bits per token
- N_OUT, 5, number of fork branches; index 0=N, 1=E, 2=S, 3=W, 4=FU
- CNT_W, 16, width of the delivered-token counter
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_cfg_mask  in  N_OUT  branch enable; sampled only when a token is loaded
- io_in_valid  in  1  producer token valid
- io_in_ready  out  1  fork can accept a token this cycle
- io_in_bits  in  WIDTH  producer data
- io_out_valid  out  N_OUT  per-branch valid
- io_out_ready  in  N_OUT  per-branch consumer ready
- io_out_bits  out  WIDTH  token data, shared by all branches
- io_busy  out  1  a token is held
- io_count  out  CNT_W  tokens fully delivered, saturating

## Operation
- State machine with two states: EMPTY and HOLD.
  - Registers: data_q[WIDTH], mask_q[N_OUT], done_q[N_OUT], count_q.
- Load: happens when io_in_valid & io_in_ready.
  - If io_cfg_mask != 0: data_q<=io_in_bits, mask_q<=io_cfg_mask, done_q<=0, next state HOLD.
  - If io_cfg_mask == 0: the token is consumed and discarded. State is unchanged and count_q is unchanged.
- Per-branch valid: io_out_valid[i] = (state==HOLD) & mask_q[i] & ~done_q[i].
- Branch fire: fire[i] = io_out_valid[i] & io_out_ready[i].
  - A firing branch sets done_q[i] at the clock edge.
  - A branch never presents the same token twice.
- Retire: happens when the state is HOLD and, for every i, ~mask_q[i] | done_q[i] | fire[i].
  - On retire, count_q increments, saturating at 2^CNT_W-1.
  - If a load occurs in the same cycle, stay in HOLD with the new token. Otherwise go to EMPTY.
- io_in_ready = (state==EMPTY) | retire. This passes through combinationally from io_out_ready, so tokens stream back-to-back.
- io_out_valid has no combinational dependence on io_out_ready or io_in_valid.
- io_out_bits = data_q. Its value is don't-care in EMPTY.
- io_busy = (state==HOLD).
- io_cfg_mask changes while in HOLD have no effect on the held token.

## Timing
- Reset (asynchronous assert, synchronous deassert at the system level): state EMPTY, done_q=0, mask_q=0, data_q=0, count_q=0.
  - After reset: io_out_valid=0, io_in_ready=1, io_busy=0, io_count=0, io_out_bits=0.
- Latency: a token loaded at edge k is visible on io_out_valid in cycle k+1.
- Throughput: one token per cycle when all masked branches are ready every cycle.
- Branches that fire in different cycles: each branch's valid drops the cycle after it fires. The others stay high until they fire.
- All branches fire in the load-following cycle: retire and new load happen on the same edge, with no bubble.
- Reset asserted mid-token: the held token is lost. No output pulses after reset.
- Count saturation: the saturated count stays at max. Retire behaviour is unaffected.

## Structure
- Shared package cgra_pkg holds:
  - Direction index constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3, DIR_FU=4, and N_DIRS=5.
  - The fork state enum {FORK_EMPTY, FORK_HOLD}.
- Natural sub-module: fork_branch, one instance per output.
  - It holds done_q[i] and computes valid and fire.
  - It exports a "satisfied" bit (~mask | done | fire) to the top-level AND-reduction.

## Test plan
- Reset then idle: check io_in_ready=1, io_out_valid=00000, io_count=0.
- Broadcast: mask=11111, all ready=1, send bits 0xA5A5A5A5.
  - Required: valid=11111 for exactly one cycle with bits=0xA5A5A5A5, then count=1, with 10 back-to-back tokens → count=10 and no bubbles.
- Staggered readiness: mask=00101.
  - Ready[0]=1 in cycle 1 → valid becomes 00100 in cycle 2.
  - Ready[2]=1 in cycle 4 → retire; io_in_ready=1 in cycle 4; count=1.
- Mask change while in HOLD: load with mask=00011, switch io_cfg_mask to 11100 before delivery. Only branches 0 and 1 assert; branches 2–4 stay 0.
- Zero mask: io_cfg_mask=0, in_valid=1 for 3 cycles → in_ready=1 throughout, no out_valid, count stays 0.
- Reset mid-token: load with mask=10000 and ready=0, then pulse reset low → valid=0, busy=0, count=0 immediately (asynchronous).
